// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter that shares one single-ported resource among N
// requesters. The registered one-hot grant drives the resource's input mux.
// An owner keeps the grant for as long as it holds its request high.
// At least one idle cycle always separates two consecutive grants.
// Priority rotates: the search starts just after the owner that last left.
//
// Parameters:
//   N         number of requesters (2..8)
//   IDW       width of gnt_id, >= ceil(log2 N)
//   MAX_HOLD  maximum consecutive grant cycles per owner (timeout build only)
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   req        level-sensitive request vector, bit i = requester i
//   gnt        registered one-hot grant, zero when nothing is granted
//   gnt_valid  registered, high exactly when gnt is non-zero
//   gnt_id     registered binary owner index, holds while gnt_valid = 0
//   timeout    registered one-cycle pulse when a grant is forcibly revoked
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a hold counter revokes a grant after
//                   MAX_HOLD cycles; when undefined, timeout is tied 0 and
//                   grants are held indefinitely.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// GRANT | one owner holds the resource until release or revocation
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  if (N < 2 || N > 8 || IDW < $clog2(N) || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter: illegal parameter combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           owner_req;
  logic [IDW-1:0] ptr_after_owner;

  // (base + offs) mod N, for base < N and offs < N
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N) sum = sum - N;
    return IDW'(sum);
  endfunction

  // Rotating-priority search: ptr, ptr+1, ..., wrapping to ptr-1.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && req[wrap_idx(ptr_q, k)]) begin
        pick_found  = 1'b1;
        pick_idx    = wrap_idx(ptr_q, k);
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << wrap_idx(ptr_q, k);
      end
    end
  end

  // The grant is one-hot, so masking req with it yields the owner's request.
  assign owner_req       = |(req & gnt_q);
  assign ptr_after_owner = (int'(gnt_id_q) == N - 1) ? '0 : gnt_id_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  // Revoke on the edge where the count would reach MAX_HOLD, which leaves
  // exactly MAX_HOLD cycles of grant.
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          gnt_d       = pick_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      GRANT: begin
        // Release takes precedence over revocation in the same cycle.
        if (!owner_req) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ptr_after_owner;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ptr_after_owner;
          timeout_d   = 1'b1;
          hold_d      = '0;
        end else begin
          hold_d      = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//
// Directed bench for rr_arbiter (N=4, MAX_HOLD=16). A behavioural model
// tracks the owner, the priority pointer and the grant age using plain
// integers. Every falling edge compares all DUT outputs against the model.
// The directed sequence also checks hand-computed literal values at key
// points.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 = nobody owns the resource
  int m_ptr   = 0;
  int m_id    = 0;
  int m_age   = 0;    // completed grant cycles of the current owner
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_id = 0; m_age = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_id    = m_owner;
            m_age   = 0;
            break;
          end
        end
      end else begin
        m_age++;
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_age == MAX_HOLD) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_to    = 1'b1;
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("gnt_id",    32'(gnt_id),    32'(m_id));
      chk("timeout",   32'(timeout),   32'(m_to));
      chk("onehot",    ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int held, bub, ngr, vcnt, tcnt;
  bit was_valid;
  int order[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    req   = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_id",    32'(gnt_id),    32'h0);
    reset = 1'b0;
    step(1);

    // 1: single request, then ptr=1 proven by 0011 granting id 1
    req = 4'b0001; step(1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_id",  32'(gnt_id), 32'h0);
    req = 4'b0000; step(1);
    chk("t1_drop", 32'(gnt_valid), 32'h0);
    req = 4'b0011; step(1);
    chk("t1_ptr1", 32'(gnt_id), 32'h1);
    req = 4'b0000; step(1);

    // 3: ptr=2, 0011 wraps around to requester 0
    req = 4'b0011; step(1);
    chk("t3_wrap_gnt", 32'(gnt), 32'h1);
    chk("t3_wrap_id",  32'(gnt_id), 32'h0);
    req = 4'b0000; step(2);

    // 2: rotation with all requesters busy
    reset = 1'b1; step(1);
    reset = 1'b0;
    req = 4'b1111;
    held = 0; bub = 0; ngr = 0; was_valid = 1'b0;
    for (int cyc = 0; cyc < 60 && ngr < 5; cyc++) begin
      step(1);
      req = 4'b1111;
      if (gnt_valid) begin
        if (!was_valid) begin
          if (ngr > 0) chk("rot_bubble", 32'(bub), 32'd1);
          order[ngr] = int'(gnt_id);
          ngr++;
          held = 0;
          bub  = 0;
        end
        held++;
        if (held == 3) req[gnt_id] = 1'b0;
      end else begin
        bub++;
      end
      was_valid = gnt_valid;
    end
    chk("rot_count", 32'(ngr), 32'd5);
    for (int i = 0; i < 5; i++) chk("rot_order", 32'(order[i]), 32'(exp_order[i]));
    req = 4'b0000; step(3);

    // 4: reset in the middle of a grant
    reset = 1'b1; step(1);
    reset = 1'b0;
    req = 4'b0100; step(1);
    chk("t4_own2", 32'(gnt_id), 32'h2);
    step(2);
    reset = 1'b1; step(1);
    chk("t4_rst_gnt",   32'(gnt),       32'h0);
    chk("t4_rst_valid", 32'(gnt_valid), 32'h0);
    chk("t4_rst_id",    32'(gnt_id),    32'h0);
    reset = 1'b0;
    req = 4'b1100; step(1);
    chk("t4_regrant", 32'(gnt_id), 32'h2);
    req = 4'b0000; step(2);

    // 6: release coincides with a new request (ptr=3 here)
    req = 4'b0001; step(1);
    chk("t6_own0", 32'(gnt), 32'h1);
    step(1);
    req = 4'b1000; step(1);
    chk("t6_bubble", 32'(gnt_valid), 32'h0);
    step(1);
    chk("t6_gnt", 32'(gnt), 32'h8);
    chk("t6_id",  32'(gnt_id), 32'h3);
    req = 4'b0000; step(2);

    // 5: long hold by requester 1
    req = 4'b0010;
    vcnt = 0; tcnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (gnt_valid) vcnt++;
      if (timeout) tcnt++;
`ifdef ARB_TIMEOUT_EN
      if (c == 16) chk("t5_last_held", 32'(gnt_valid), 32'h1);
      if (c == 17) begin
        chk("t5_revoked", 32'(gnt_valid), 32'h0);
        chk("t5_pulse",   32'(timeout),   32'h1);
      end
      if (c == 18) chk("t5_regrant", 32'(gnt), 32'h2);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    chk("t5_valid_cycles", 32'(vcnt), 32'd19);
    chk("t5_timeouts",     32'(tcnt), 32'd1);
`else
    chk("t5_valid_cycles", 32'(vcnt), 32'd20);
    chk("t5_timeouts",     32'(tcnt), 32'd0);
`endif
    req = 4'b0000; step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
